// File: rtl/rat_io_pkg.sv
// Shared constants and helpers for the 16-channel input port bank.
package rat_io_pkg;

    localparam int NUM_PORTS = 16;
    localparam int SEL_W     = 4;

    typedef logic [NUM_PORTS-1:0] port_vec_t;

    function automatic port_vec_t sel_onehot(input logic [SEL_W-1:0] sel, input logic en);
        port_vec_t v;
        v = {NUM_PORTS{1'b0}};
        if (en) begin
            v[sel] = 1'b1;
        end else begin
            v = {NUM_PORTS{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/in_port_bank_if.sv
// CPU-side and pin-side bus of the input port bank.
interface in_port_bank_if
    import rat_io_pkg::*;
#(
    parameter int n = 8
);
    logic [NUM_PORTS*n-1:0] IN_BUS;
    logic [NUM_PORTS*n-1:0] Q_BUS;
    logic [SEL_W-1:0]       RD_SEL;
    logic                   RD_ACK;
    logic                   MASK_WE;
    logic [NUM_PORTS-1:0]   MASK_IN;
    logic [NUM_PORTS-1:0]   NEW_FLAGS;
    logic [NUM_PORTS-1:0]   OVR_FLAGS;
    logic                   IRQ;

    modport master (
        output IN_BUS, RD_SEL, RD_ACK, MASK_WE, MASK_IN,
        input  Q_BUS, NEW_FLAGS, OVR_FLAGS, IRQ
    );

    modport slave (
        input  IN_BUS, RD_SEL, RD_ACK, MASK_WE, MASK_IN,
        output Q_BUS, NEW_FLAGS, OVR_FLAGS, IRQ
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one n-bit asynchronous input channel.
module sync_2ff #(
    parameter int n = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [n-1:0] D,
    output logic [n-1:0] Q
);
    logic [n-1:0] s1_r;
    logic [n-1:0] s2_r;

    // Metastability-settling flop pair
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_r <= {n{1'b0}};
            s2_r <= {n{1'b0}};
        end else begin
            s1_r <= D;
            s2_r <= s1_r;
        end
    end

    assign Q = s2_r;
endmodule

// File: rtl/in_port_bank.sv
// Synchronized 16-channel input bank with change-detect flags, overrun
// tracking and a masked, registered interrupt request.
module in_port_bank
    import rat_io_pkg::*;
#(
    parameter int n = 8
) (
    input logic           CLK,
    input logic           RST,
    in_port_bank_if.slave bus
);
    logic [n-1:0] s2_s     [NUM_PORTS];
    logic [n-1:0] q_r      [NUM_PORTS];
    logic [n-1:0] q_nxt_s  [NUM_PORTS];
    logic [NUM_PORTS*n-1:0] q_bus_s;

    port_vec_t chg_s;
    port_vec_t ack_s;
    port_vec_t new_r;
    port_vec_t new_nxt_s;
    port_vec_t ovr_r;
    port_vec_t ovr_nxt_s;
    port_vec_t mask_r;
    port_vec_t mask_nxt_s;
    logic      irq_r;
    logic      irq_nxt_s;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_sync
        sync_2ff #(.n(n)) u_sync (
            .CLK (CLK),
            .RST (RST),
            .D   (bus.IN_BUS[k*n +: n]),
            .Q   (s2_s[k])
        );
    end

    // Next-state for captured values, flags, mask and interrupt
    always_comb begin
        ack_s      = sel_onehot(bus.RD_SEL, bus.RD_ACK);
        chg_s      = {NUM_PORTS{1'b0}};
        q_nxt_s    = q_r;
        new_nxt_s  = new_r;
        ovr_nxt_s  = ovr_r;
        for (int k = 0; k < NUM_PORTS; k++) begin
            chg_s[k] = (s2_s[k] != q_r[k]);
            // A change always sets the new flag, even when acked the same edge.
            if (chg_s[k]) begin
                q_nxt_s[k]   = s2_s[k];
                new_nxt_s[k] = 1'b1;
            end else if (ack_s[k]) begin
                new_nxt_s[k] = 1'b0;
            end else begin
                new_nxt_s[k] = new_r[k];
            end
            if (ack_s[k]) begin
                ovr_nxt_s[k] = 1'b0;
            end else if (chg_s[k] && new_r[k]) begin
                ovr_nxt_s[k] = 1'b1;
            end else begin
                ovr_nxt_s[k] = ovr_r[k];
            end
        end
        if (bus.MASK_WE) begin
            mask_nxt_s = bus.MASK_IN;
        end else begin
            mask_nxt_s = mask_r;
        end
        irq_nxt_s = |(new_nxt_s & mask_nxt_s);
    end

    // State registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                q_r[k] <= {n{1'b0}};
            end
            new_r  <= {NUM_PORTS{1'b0}};
            ovr_r  <= {NUM_PORTS{1'b0}};
            mask_r <= {NUM_PORTS{1'b0}};
            irq_r  <= 1'b0;
        end else begin
            q_r    <= q_nxt_s;
            new_r  <= new_nxt_s;
            ovr_r  <= ovr_nxt_s;
            mask_r <= mask_nxt_s;
            irq_r  <= irq_nxt_s;
        end
    end

    // Pack captured channels onto the mux-facing bus
    always_comb begin
        q_bus_s = {(NUM_PORTS*n){1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            q_bus_s[k*n +: n] = q_r[k];
        end
    end

    assign bus.Q_BUS     = q_bus_s;
    assign bus.NEW_FLAGS = new_r;
    assign bus.OVR_FLAGS = ovr_r;
    assign bus.IRQ       = irq_r;
endmodule

// File: tb/tb_in_port_bank.sv
// Directed self-checking bench for in_port_bank (n = 8).
module tb_in_port_bank;
    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_bad;

    in_port_bank_if #(.n(8)) bus ();

    in_port_bank #(.n(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [7:0] v);
        bus.IN_BUS[k*8 +: 8] = v;
    endtask

    task automatic ack(input int k);
        bus.RD_SEL = 4'(k);
        bus.RD_ACK = 1'b1;
        tick();
        bus.RD_ACK = 1'b0;
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.IN_BUS  = 128'd0;
        bus.RD_ACK  = 1'b0;
        bus.MASK_WE = 1'b0;
        bus.MASK_IN = 16'h0000;
        bus.RD_SEL  = 4'd0;
        tick();
        RST = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.IN_BUS  = {128{1'b1}};
        bus.RD_ACK  = 1'b0;
        bus.MASK_WE = 1'b0;
        bus.MASK_IN = 16'h0000;
        bus.RD_SEL  = 4'd0;
        tick();
        tick();
        n_cmp++;
        if (bus.Q_BUS !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_q: got %h expected 0", bus.Q_BUS);
        end
        chk16("reset_new", bus.NEW_FLAGS, 16'h0000);
        chk16("reset_ovr", bus.OVR_FLAGS, 16'h0000);
        chk16("reset_irq", {15'd0, bus.IRQ}, 16'h0000);
        RST = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.Q_BUS !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_latency_e1: got %h expected 0", bus.Q_BUS);
        end
        tick();
        n_cmp++;
        if (bus.Q_BUS !== {128{1'b1}}) begin
            n_bad++;
            $display("FAIL reset_release_q: got %h expected all ff", bus.Q_BUS);
        end
        chk16("reset_release_new", bus.NEW_FLAGS, 16'hFFFF);
        chk16("reset_release_irq", {15'd0, bus.IRQ}, 16'h0000);
        chk16("reset_release_ovr", bus.OVR_FLAGS, 16'h0000);
    endtask

    task automatic test_latency_irq();
        do_reset();
        bus.MASK_WE = 1'b1;
        bus.MASK_IN = 16'h0004;
        tick();
        bus.MASK_WE = 1'b0;
        set_ch(2, 8'h5A);
        tick();
        tick();
        chk16("lat_e1_q2", {8'd0, bus.Q_BUS[23:16]}, 16'h0000);
        chk16("lat_e1_irq", {15'd0, bus.IRQ}, 16'h0000);
        tick();
        chk16("lat_e2_q2", {8'd0, bus.Q_BUS[23:16]}, 16'h005A);
        chk16("lat_e2_new", bus.NEW_FLAGS, 16'h0004);
        chk16("lat_e2_irq", {15'd0, bus.IRQ}, 16'h0001);
        ack(2);
        chk16("lat_ack_new", bus.NEW_FLAGS, 16'h0000);
        chk16("lat_ack_irq", {15'd0, bus.IRQ}, 16'h0000);
    endtask

    task automatic test_overrun();
        set_ch(7, 8'h11);
        repeat (3) tick();
        chk16("ovr_first_new", bus.NEW_FLAGS, 16'h0080);
        chk16("ovr_first_ovr", bus.OVR_FLAGS, 16'h0000);
        set_ch(7, 8'h22);
        repeat (3) tick();
        chk16("ovr_q7", {8'd0, bus.Q_BUS[63:56]}, 16'h0022);
        chk16("ovr_new", bus.NEW_FLAGS, 16'h0080);
        chk16("ovr_ovr", bus.OVR_FLAGS, 16'h0080);
        ack(7);
        chk16("ovr_ack_new", bus.NEW_FLAGS, 16'h0000);
        chk16("ovr_ack_ovr", bus.OVR_FLAGS, 16'h0000);
        chk16("ovr_ack_q7", {8'd0, bus.Q_BUS[63:56]}, 16'h0022);
    endtask

    task automatic test_collision();
        logic [127:0] exp_q;
        set_ch(3, 8'h01);
        repeat (3) tick();
        chk16("col_pre_new", bus.NEW_FLAGS, 16'h0008);
        set_ch(3, 8'h02);
        tick();
        tick();
        ack(3);
        chk16("col_new", bus.NEW_FLAGS, 16'h0008);
        chk16("col_q3", {8'd0, bus.Q_BUS[31:24]}, 16'h0002);
        chk16("col_ovr", bus.OVR_FLAGS, 16'h0000);
        ack(3);
        chk16("col_clear_new", bus.NEW_FLAGS, 16'h0000);
        ack(5);
        chk16("harmless_new", bus.NEW_FLAGS, 16'h0000);
        chk16("harmless_ovr", bus.OVR_FLAGS, 16'h0000);
        exp_q = 128'd0;
        exp_q[23:16] = 8'h5A;
        exp_q[31:24] = 8'h02;
        exp_q[63:56] = 8'h22;
        n_cmp++;
        if (bus.Q_BUS !== exp_q) begin
            n_bad++;
            $display("FAIL harmless_q: got %h expected %h", bus.Q_BUS, exp_q);
        end
    endtask

    task automatic test_masking();
        set_ch(0, 8'h33);
        set_ch(8, 8'h44);
        bus.MASK_WE = 1'b1;
        bus.MASK_IN = 16'h0001;
        tick();
        bus.MASK_WE = 1'b0;
        tick();
        tick();
        chk16("mask_new", bus.NEW_FLAGS, 16'h0101);
        chk16("mask_irq", {15'd0, bus.IRQ}, 16'h0001);
        bus.MASK_WE = 1'b1;
        bus.MASK_IN = 16'h0000;
        tick();
        bus.MASK_WE = 1'b0;
        chk16("mask_off_irq", {15'd0, bus.IRQ}, 16'h0000);
        chk16("mask_off_new", bus.NEW_FLAGS, 16'h0101);
    endtask

    task automatic test_async_reset();
        bus.MASK_WE = 1'b1;
        bus.MASK_IN = 16'h0101;
        tick();
        bus.MASK_WE = 1'b0;
        chk16("arst_pre_irq", {15'd0, bus.IRQ}, 16'h0001);
        #2;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (bus.Q_BUS !== 128'd0) begin
            n_bad++;
            $display("FAIL arst_q: got %h expected 0", bus.Q_BUS);
        end
        chk16("arst_new", bus.NEW_FLAGS, 16'h0000);
        chk16("arst_ovr", bus.OVR_FLAGS, 16'h0000);
        chk16("arst_irq", {15'd0, bus.IRQ}, 16'h0000);
        tick();
        RST = 1'b0;
        tick();
        chk16("arst_e0_new", bus.NEW_FLAGS, 16'h0000);
        bus.MASK_WE = 1'b1;
        bus.MASK_IN = 16'h0004;
        tick();
        bus.MASK_WE = 1'b0;
        chk16("arst_e1_irq", {15'd0, bus.IRQ}, 16'h0000);
        tick();
        chk16("arst_e2_new", bus.NEW_FLAGS, 16'h018D);
        chk16("arst_e2_irq", {15'd0, bus.IRQ}, 16'h0001);
        chk16("arst_e2_q2", {8'd0, bus.Q_BUS[23:16]}, 16'h005A);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_latency_irq();
        test_overrun();
        test_collision();
        test_masking();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
